// File: rtl/keep_n_ctrl_pkg.sv
// Shared types and constants for the keep-one-in-N reconfiguration controller.
package keep_n_ctrl_pkg;

  // Reconfiguration sequencer states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2,
    APPLY = 2'd3
  } state_e;

  // Default settings-bus addresses of the staged values.
  localparam int SR_N_DEFAULT           = 129;
  localparam int SR_VECTOR_MODE_DEFAULT = 130;

  // Values the active and staged configuration take out of reset.
  localparam logic [15:0] N_RST  = 16'd1;
  localparam logic        VM_RST = 1'b1;

endpackage : keep_n_ctrl_pkg

// File: rtl/setting_reg.sv
// Single settings-bus register: captures in_data when strobed at its address.
module setting_reg #(
  parameter int               MY_ADDR  = 0,
  parameter int               AWIDTH   = 8,
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] AT_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe,
  input  logic [AWIDTH-1:0] addr,
  input  logic [WIDTH-1:0]  in_data,
  output logic [WIDTH-1:0]  out
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  // Load on an address match, otherwise hold.
  always_comb begin
    // NOTE: assigning a default before any condition keeps this purely combinational (no latch).
    out_d = out_q;
    if (strobe && (addr == AWIDTH'(MY_ADDR))) begin
      out_d = in_data;
    end
  end

  // Storage with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      out_q <= AT_RESET;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : setting_reg

// File: rtl/keep_n_cfg_ctrl.sv
// Staged reconfiguration of a keep-one-in-N datapath: holds new settings until
// the current packet ends, drains the datapath output, pulses a clear, then applies.
module keep_n_cfg_ctrl
  import keep_n_ctrl_pkg::*;
#(
  parameter int SR_N           = SR_N_DEFAULT,
  parameter int SR_VECTOR_MODE = SR_VECTOR_MODE_DEFAULT,
  parameter int IDLE_CYCLES    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        flush,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic        m_tvalid,
  input  logic        m_tready,
  input  logic        o_tvalid,
  input  logic        o_tready,
  output logic        dp_clear,
  output logic [15:0] n,
  output logic        vector_mode,
  output logic        pending,
  output logic        busy
);

  localparam logic [7:0] IDLE_MAX = 8'(IDLE_CYCLES);

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic        in_pkt_q, in_pkt_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;
  logic [15:0] n_q, n_d;
  logic        vm_q, vm_d;

  logic        rst;
  logic [15:0] n_wr_data;
  logic [15:0] staged_n;
  logic        staged_vm;
  logic        wr_n, wr_vm, wr_any;
  logic        pass, accept;
  logic        unused_inputs;

  // Upper settings bits and the output-ready monitor carry no information here.
  assign unused_inputs = ^{set_data[31:16], o_tready};

  assign rst       = ~reset_n;
  assign n_wr_data = (set_data[15:0] == 16'd0) ? 16'd1 : set_data[15:0];
  assign wr_n      = set_stb && (set_addr == 8'(SR_N));
  assign wr_vm     = set_stb && (set_addr == 8'(SR_VECTOR_MODE));
  assign wr_any    = wr_n || wr_vm;

  setting_reg #(
    .MY_ADDR (SR_N),
    .AWIDTH  (8),
    .WIDTH   (16),
    .AT_RESET(N_RST)
  ) u_staged_n (
    .clk    (clk),
    .rst    (rst),
    .strobe (set_stb),
    .addr   (set_addr),
    .in_data(n_wr_data),
    .out    (staged_n)
  );

  setting_reg #(
    .MY_ADDR (SR_VECTOR_MODE),
    .AWIDTH  (8),
    .WIDTH   (1),
    .AT_RESET(VM_RST)
  ) u_staged_vm (
    .clk    (clk),
    .rst    (rst),
    .strobe (set_stb),
    .addr   (set_addr),
    .in_data(set_data[0]),
    .out    (staged_vm)
  );

  // Stream gate: transparent in RUN unless a change is waiting at a packet boundary.
  assign pass     = (state_q == RUN) && (!pending_q || in_pkt_q);
  assign m_tvalid = pass && s_tvalid;
  assign s_tready = pass && m_tready;
  assign accept   = pass && s_tvalid && m_tready;

  // Packet tracking, pending flag, quiet-cycle counter and active configuration.
  always_comb begin
    in_pkt_d   = in_pkt_q;
    pending_d  = pending_q;
    idle_cnt_d = 8'd0;
    n_d        = n_q;
    vm_d       = vm_q;

    if (accept) begin
      in_pkt_d = !s_tlast;
    end

    if (state_q == DRAIN) begin
      if (o_tvalid) begin
        idle_cnt_d = 8'd0;
      end else if (idle_cnt_q >= IDLE_MAX) begin
        idle_cnt_d = IDLE_MAX;
      end else begin
        idle_cnt_d = idle_cnt_q + 8'd1;
      end
    end

    if (state_q == APPLY) begin
      n_d       = staged_n;
      vm_d      = staged_vm;
      pending_d = 1'b0;
    end

    // A write landing in the APPLY cycle re-arms the sequence.
    if (wr_any) begin
      pending_d = 1'b1;
    end

    if (flush) begin
      in_pkt_d   = 1'b0;
      idle_cnt_d = 8'd0;
      pending_d  = 1'b1;
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (pending_q && !in_pkt_q) state_d = DRAIN;
      DRAIN:   if (idle_cnt_d == IDLE_MAX) state_d = CLEAR;
      CLEAR:   state_d = APPLY;
      APPLY:   state_d = RUN;
      default: state_d = RUN;
    endcase
    if (flush) begin
      state_d = CLEAR;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    dp_clear = (state_q == CLEAR);
    busy     = (state_q != RUN);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Control and configuration registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q  <= 1'b0;
      in_pkt_q   <= 1'b0;
      idle_cnt_q <= 8'd0;
      n_q        <= N_RST;
      vm_q       <= VM_RST;
    end else begin
      pending_q  <= pending_d;
      in_pkt_q   <= in_pkt_d;
      idle_cnt_q <= idle_cnt_d;
      n_q        <= n_d;
      vm_q       <= vm_d;
    end
  end

  assign n           = n_q;
  assign vector_mode = vm_q;
  assign pending     = pending_q;

endmodule : keep_n_cfg_ctrl

// File: tb/tb_keep_n_cfg_ctrl.sv
// Self-checking bench for keep_n_cfg_ctrl: directed scenarios plus random
// traffic, compared every cycle against a behavioural reference model.
module tb_keep_n_cfg_ctrl;

  localparam int ADDR_N  = 129;
  localparam int ADDR_VM = 130;
  localparam int IDLE    = 16;

  localparam int PH_RUN   = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_CLEAR = 2;
  localparam int PH_APPLY = 3;

  logic        clk;
  logic        reset_n;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        flush;
  logic        s_tvalid, s_tlast, s_tready;
  logic        m_tvalid, m_tready;
  logic        o_tvalid, o_tready;
  logic        dp_clear;
  logic [15:0] n;
  logic        vector_mode, pending, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int clr_seen = 0;
  int beats_seen = 0;

  // Reference model state.
  int m_phase;
  bit m_pending, m_in_pkt, m_vm, m_staged_vm;
  int m_quiet, m_n, m_staged_n;

  keep_n_cfg_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .flush      (flush),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .o_tvalid   (o_tvalid),
    .o_tready   (o_tready),
    .dp_clear   (dp_clear),
    .n          (n),
    .vector_mode(vector_mode),
    .pending    (pending),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural rules applied at each clock edge.
  task automatic model_step();
    bit pass_now, acc, wr_n, wr_vm, was_in_pkt, was_pending;
    if (!reset_n) begin
      m_phase = PH_RUN; m_pending = 0; m_in_pkt = 0; m_quiet = 0;
      m_n = 1; m_vm = 1; m_staged_n = 1; m_staged_vm = 1;
      return;
    end
    pass_now    = (m_phase == PH_RUN) && (!m_pending || m_in_pkt);
    acc         = pass_now && s_tvalid && m_tready;
    wr_n        = set_stb && (set_addr == 8'(ADDR_N));
    wr_vm       = set_stb && (set_addr == 8'(ADDR_VM));
    was_in_pkt  = m_in_pkt;
    was_pending = m_pending;
    // The apply copies the staged values held before this edge.
    if (m_phase == PH_APPLY) begin
      m_n  = m_staged_n;
      m_vm = m_staged_vm;
    end
    if (wr_n)  m_staged_n  = (set_data[15:0] == 16'd0) ? 1 : int'(set_data[15:0]);
    if (wr_vm) m_staged_vm = set_data[0];
    if (flush) begin
      m_phase = PH_CLEAR; m_in_pkt = 0; m_quiet = 0; m_pending = 1;
      return;
    end
    if (acc) m_in_pkt = !s_tlast;
    case (m_phase)
      PH_RUN:   if (was_pending && !was_in_pkt) m_phase = PH_DRAIN;
      PH_DRAIN: begin
        m_quiet = o_tvalid ? 0 : m_quiet + 1;
        if (m_quiet >= IDLE) begin
          m_phase = PH_CLEAR;
          m_quiet = 0;
        end
      end
      PH_CLEAR: m_phase = PH_APPLY;
      default:  begin m_phase = PH_RUN; m_pending = 0; end
    endcase
    if (wr_n || wr_vm) m_pending = 1;
  endtask

  // Compare all outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    bit pass_now;
    @(negedge clk);
    pass_now = (m_phase == PH_RUN) && (!m_pending || m_in_pkt);
    check("m_tvalid", 32'(m_tvalid), 32'(pass_now && s_tvalid));
    check("s_tready", 32'(s_tready), 32'(pass_now && m_tready));
    check("dp_clear", 32'(dp_clear), 32'(m_phase == PH_CLEAR));
    check("busy", 32'(busy), 32'(m_phase != PH_RUN));
    check("pending", 32'(pending), 32'(m_pending));
    check("n", 32'(n), 32'(m_n));
    check("vector_mode", 32'(vector_mode), 32'(m_vm));
    if (dp_clear === 1'b1) clr_seen++;
    if (s_tvalid && (s_tready === 1'b1)) beats_seen++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    set_stb = 0; set_addr = 8'd0; set_data = 32'd0; flush = 0;
    s_tvalid = 0; s_tlast = 0; m_tready = 1; o_tvalid = 0; o_tready = 1;
  endtask

  task automatic write_reg(input int addr, input logic [31:0] data);
    set_stb = 1; set_addr = 8'(addr); set_data = data;
    tick();
    set_stb = 0;
  endtask

  initial begin
    int k;
    idle_inputs();
    reset_n = 0;
    @(posedge clk);
    model_step();
    #1;
    tick();
    reset_n = 1;
    check("rst_n", 32'(n), 32'd1);
    check("rst_vm", 32'(vector_mode), 32'd1);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dp_clear", 32'(dp_clear), 32'd0);

    // Idle write: blocked next cycle, one clear after 16 quiet cycles.
    clr_seen = 0;
    write_reg(ADDR_N, 32'd4);
    s_tvalid = 1;
    #1;
    check("idle_wr_blocked", 32'(s_tready), 32'd0);
    tick();
    s_tvalid = 0;
    repeat (25) tick();
    check("idle_wr_clears", 32'(clr_seen), 32'd1);
    check("idle_wr_n", 32'(n), 32'd4);
    check("idle_wr_pending", 32'(pending), 32'd0);
    check("idle_wr_busy", 32'(busy), 32'd0);

    // Write during beat 3 of a 10-beat packet: packet is never split.
    beats_seen = 0;
    for (int b = 0; b < 10; b++) begin
      s_tvalid = 1; s_tlast = (b == 9);
      set_stb = (b == 2); set_addr = 8'(ADDR_N); set_data = 32'd8;
      tick();
    end
    set_stb = 0; s_tvalid = 1; s_tlast = 0;
    #1;
    check("pkt_beats", 32'(beats_seen), 32'd10);
    check("pkt_ready_after_last", 32'(s_tready), 32'd0);
    check("pkt_n_held", 32'(n), 32'd4);
    s_tvalid = 0;
    repeat (25) tick();
    check("pkt_n_applied", 32'(n), 32'd8);

    // Output activity every 10 cycles keeps the drain from completing.
    clr_seen = 0;
    write_reg(ADDR_VM, 32'd0);
    write_reg(ADDR_N, 32'd3);
    for (int i = 0; i < 60; i++) begin
      o_tvalid = ((i % 10) == 9);
      tick();
    end
    check("drain_no_clear", 32'(clr_seen), 32'd0);
    o_tvalid = 0;
    repeat (25) tick();
    check("drain_one_clear", 32'(clr_seen), 32'd1);
    check("drain_n", 32'(n), 32'd3);
    check("drain_vm", 32'(vector_mode), 32'd0);

    // N=0 maps to 1; a write in the APPLY cycle forces a second sequence.
    clr_seen = 0;
    write_reg(ADDR_N, 32'd0);
    k = 0;
    while (clr_seen == 0 && k < 60) begin
      tick();
      k++;
    end
    check("apply_reached", 32'(clr_seen), 32'd1);
    write_reg(ADDR_N, 32'd5);
    check("apply_n_zero_as_one", 32'(n), 32'd1);
    check("apply_pending_kept", 32'(pending), 32'd1);
    repeat (25) tick();
    check("apply_second_clear", 32'(clr_seen), 32'd2);
    check("apply_n_five", 32'(n), 32'd5);

    // Flush mid-packet: clear on the next cycle and packet state dropped.
    s_tvalid = 1; s_tlast = 0;
    tick();
    s_tvalid = 0; flush = 1;
    tick();
    flush = 0;
    check("flush_dp_clear", 32'(dp_clear), 32'd1);
    repeat (3) tick();
    s_tvalid = 1; s_tlast = 1;
    tick();
    s_tvalid = 0; s_tlast = 0;
    repeat (3) tick();

    // Reset during DRAIN abandons the sequence silently.
    write_reg(ADDR_N, 32'd9);
    tick();
    reset_n = 0;
    clr_seen = 0;
    tick();
    reset_n = 1;
    check("rst_drain_busy", 32'(busy), 32'd0);
    check("rst_drain_n", 32'(n), 32'd1);
    check("rst_drain_vm", 32'(vector_mode), 32'd1);
    repeat (25) tick();
    check("rst_drain_no_clear", 32'(clr_seen), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset_n  = ($urandom_range(0, 299) != 0);
      flush    = ($urandom_range(0, 149) == 0);
      s_tvalid = 1'($urandom_range(0, 1));
      s_tlast  = ($urandom_range(0, 5) == 0);
      m_tready = ($urandom_range(0, 3) != 0);
      o_tvalid = ($urandom_range(0, 19) == 0);
      o_tready = 1'($urandom_range(0, 1));
      set_stb  = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 2))
        0:       set_addr = 8'(ADDR_N);
        1:       set_addr = 8'(ADDR_VM);
        default: set_addr = 8'($urandom_range(0, 255));
      endcase
      set_data = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_keep_n_cfg_ctrl
